uart_tx_sched: RTL and testbench

Two-requester scheduler in front of the UART transmitter (`uartTX_top`). It arbitrates round-robin between two byte sources and hands one byte at a time to the transmitter as a single-cycle `data_valid` pulse. It latches the parity configuration per frame and waits for the transmitter's `busy` to rise and fall before issuing the next byte. It flags a transmitter that never starts a frame.

---
 rtl/uart_tx_sched.sv | 104 ++++++++++
 tb/tb_uart_tx_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that feeds one byte at a time from two requesters into the UART
// transmitter, latching parity config per frame and flagging a transmitter that never starts.
module uart_tx_sched #(
  parameter int unsigned dataWidth    = 8,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dataWidth-1:0] req0_data,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [dataWidth-1:0] req1_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 cfg_par_en,
  input  logic                 cfg_par_type,
  input  logic                 tx_busy,
  output logic [dataWidth-1:0] tx_p_data,
  output logic                 tx_data_valid,
  output logic                 tx_par_en,
  output logic                 tx_par_type,
  output logic                 grant_id,
  output logic                 timeout_err
);

  localparam int unsigned CntW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitStart, StWaitDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            last_grant_q;
  logic            sel;
  logic            idle_free;
  logic            accept;

  // A lone valid requester wins outright; a tie goes to whoever was not granted last.
  always_comb begin
    sel = ~last_grant_q;
    if (req0_valid && !req1_valid) begin
      sel = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      sel = 1'b1;
    end
  end

  assign idle_free  = (state_q == StIdle) && !tx_busy;
  assign req0_ready = idle_free && !sel;
  assign req1_ready = idle_free && sel;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      tx_par_en     <= 1'b0;
      tx_par_type   <= 1'b0;
      grant_id      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      tx_data_valid <= 1'b0;
      timeout_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            tx_p_data    <= sel ? req1_data : req0_data;
            tx_par_en    <= cfg_par_en;
            tx_par_type  <= cfg_par_type;
            grant_id     <= sel;
            last_grant_q <= sel;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          tx_data_valid <= 1'b1;
          cnt_q         <= '0;
          state_q       <= StWaitStart;
        end
        StWaitStart: begin
          // busy wins over the timeout on the final wait cycle
          if (tx_busy) begin
            state_q <= StWaitDone;
          end else if (cnt_q == CntMax) begin
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched: a timeline-based reference model predicts grants,
// strobes, latched frame fields and timeouts, with an occasional reset while a frame is busy.
module tb_uart_tx_sched;

  localparam int unsigned DW = 8;
  localparam int unsigned T  = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic          cfg_par_en, cfg_par_type, tx_busy;
  logic [DW-1:0] tx_p_data;
  logic          tx_data_valid, tx_par_en, tx_par_type, grant_id, timeout_err;

  uart_tx_sched #(.dataWidth(DW), .BUSY_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_data    (req0_data),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req1_data    (req1_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .cfg_par_en   (cfg_par_en),
    .cfg_par_type (cfg_par_type),
    .tx_busy      (tx_busy),
    .tx_p_data    (tx_p_data),
    .tx_data_valid(tx_data_valid),
    .tx_par_en    (tx_par_en),
    .tx_par_type  (tx_par_type),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame timeline measured in clock edges since reset.
  int          n_edge;
  bit          occ, started, last;
  int          acc_edge;
  logic [7:0]  e_data;
  bit          e_pen, e_pt, e_gid, e_dv, e_terr;
  bit          pend[2];
  logic [7:0]  pdata[2];
  int          bz_start, bz_end;
  int          n_frames, n_tmo, n_rst;

  function automatic int pick(input bit v0, input bit v1, input bit lg);
    if (v0 && v1) return lg ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    occ = 0; started = 0; last = 1;
    e_data = '0; e_pen = 0; e_pt = 0; e_gid = 0; e_dv = 0; e_terr = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check_val({pfx, ".tx_p_data"}, 32'(tx_p_data), 32'(e_data));
    check_val({pfx, ".tx_data_valid"}, 32'(tx_data_valid), 32'(e_dv));
    check_val({pfx, ".tx_par_en"}, 32'(tx_par_en), 32'(e_pen));
    check_val({pfx, ".tx_par_type"}, 32'(tx_par_type), 32'(e_pt));
    check_val({pfx, ".grant_id"}, 32'(grant_id), 32'(e_gid));
    check_val({pfx, ".timeout_err"}, 32'(timeout_err), 32'(e_terr));
  endtask

  task automatic model_step();
    int s;
    n_edge++;
    e_dv = 0;
    e_terr = 0;
    if (!rst) return;
    if (!occ) begin
      s = pick(req0_valid, req1_valid, last);
      if (!tx_busy && s >= 0) begin
        occ = 1; started = 0; acc_edge = n_edge;
        e_data = pdata[s]; e_pen = cfg_par_en; e_pt = cfg_par_type; e_gid = s[0];
        last = s[0]; pend[s] = 0; n_frames++;
        // Transmitter plan: sometimes never starts in time, otherwise starts within the window.
        if ($urandom_range(0, 4) == 0) begin
          bz_start = n_edge + 1 + T;
          bz_end   = bz_start + $urandom_range(0, 3);
        end else begin
          bz_start = n_edge + 1 + $urandom_range(0, T - 1);
          bz_end   = bz_start + $urandom_range(1, 8);
        end
      end
    end else if (n_edge == acc_edge + 1) begin
      e_dv = 1;
    end else if (!started) begin
      if (tx_busy) begin
        started = 1;
      end else if (n_edge == acc_edge + 1 + T) begin
        occ = 0; e_terr = 1; n_tmo++;
      end
    end else if (!tx_busy) begin
      occ = 0;
    end
  endtask

  initial begin
    int s;
    rst = 1'b0;
    req0_data = '0; req1_data = '0; req0_valid = 0; req1_valid = 0;
    cfg_par_en = 0; cfg_par_type = 0; tx_busy = 0;
    n_edge = 0; bz_start = 0; bz_end = 0; n_frames = 0; n_tmo = 0; n_rst = 0;
    pend[0] = 0; pend[1] = 0; pdata[0] = '0; pdata[1] = '0;
    model_reset();
    #2 check_outputs("reset");
    @(negedge clk);
    check_outputs("reset_hold");
    rst = 1'b1;
    pend[0] = 1; pdata[0] = 8'hA5;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      check_outputs("run");
      if (!rst) rst = 1'b1;
      else if (cyc > 100 && occ && started && n_rst < 3 && $urandom_range(0, 5) == 0) begin
        rst = 1'b0;
        n_rst++;
        model_reset();
        #1 check_outputs("midframe_rst");
      end
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          pdata[i] = 8'($urandom);
        end
      end
      req0_valid = pend[0]; req0_data = pdata[0];
      req1_valid = pend[1]; req1_data = pdata[1];
      if (cyc == 0) begin
        cfg_par_en = 1; cfg_par_type = 0;
      end else begin
        cfg_par_en = 1'($urandom); cfg_par_type = 1'($urandom);
      end
      tx_busy = (n_edge >= bz_start) && (n_edge < bz_end);
      #1;
      if (rst && (req0_valid || req1_valid)) begin
        s = pick(req0_valid, req1_valid, last);
        check_val("req0_ready", 32'(req0_ready), 32'(!occ && !tx_busy && s == 0));
        check_val("req1_ready", 32'(req1_ready), 32'(!occ && !tx_busy && s == 1));
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    check_val("saw_timeout", 32'(n_tmo > 0), 32'd1);
    check_val("saw_reset", 32'(n_rst > 0), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
